// File: rtl/ssd_pkg.sv
// Shared glyph constants and scan FSM encoding for the seven-segment scan driver.
// Glyph bit order is {g,f,e,d,c,b,a}, active-high before any output inversion.
package ssd_pkg;

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_ON    = 1'b1
    } scan_state_e;

    localparam logic [6:0] GLYPH_MINUS = 7'b1000000;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

    // Nibble n occupies bits [n*7 +: 7]; F is the leftmost entry.
    localparam logic [16*7-1:0] HEX_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
        return HEX_TABLE[nibble*7 +: 7];
    endfunction

endpackage

// File: rtl/ssd_digit_decode.sv
// One digit of the blanking / minus-placement chain, evaluated from MSB down to LSB.
// A pending minus request travels down until a position accepts it; reaching past the LSB means it was lost.
module ssd_digit_decode
    import ssd_pkg::*;
#(
    parameter bit IS_LSB = 1'b0
) (
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    input  logic       minus_i,
    input  logic       place_ok_i,
    output logic [6:0] glyph_o,
    output logic       blank_o,
    output logic       minus_o
);

    logic zero;
    logic take;

    always_comb begin
        zero    = (nibble_i == 4'h0);
        blank_o = blank_i & zero & (IS_LSB == 1'b0);
        take    = minus_i & place_ok_i & zero & (IS_LSB == 1'b0);
        minus_o = minus_i & ~take;
        if (take) begin
            glyph_o = GLYPH_MINUS;
        end else if (blank_o) begin
            glyph_o = GLYPH_BLANK;
        end else begin
            glyph_o = hex_glyph(nibble_i);
        end
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver with guard band, leading-zero blanking and minus sign.
// Display content comes only from shadow registers captured on load.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int   NUM_DIGITS = 4,
    parameter int   SCAN_DIV   = 50000,
    parameter int   GUARD      = 16,
    parameter logic SEG_INVERT = 1'b0,
    parameter logic AN_INVERT  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    neg,
    input  logic                    blank_en,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    minus_lost
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   dp_in_q;
    logic                    neg_q;
    logic                    blank_en_q;

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    scan_state_e             state_q, state_d;

    logic [6:0]              seg_q, seg_d;
    logic                    dp_out_q, dp_out_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    minus_lost_q;

    logic [6:0]              glyph [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   blank_in, blank_out;
    logic [NUM_DIGITS-1:0]   minus_in, minus_out;
    logic [NUM_DIGITS-1:0]   place_ok;
    logic                    any_nz;
    logic                    lsb_blank_unused;

    assign any_nz           = |digits_q;
    assign lsb_blank_unused = blank_out[0];

    // Blanking mode: a leading zero takes the minus when the digit to its right is shown.
    // Non-blanking mode: only a zero MSB can take it.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign blank_in[gi] = blank_en_q;
                assign minus_in[gi] = neg_q & any_nz;
            end else begin : g_mid
                assign blank_in[gi] = blank_out[gi+1];
                assign minus_in[gi] = minus_out[gi+1];
            end

            if (gi == 0) begin : g_lsb_place
                assign place_ok[gi] = 1'b0;
            end else if (gi == 1) begin : g_one_place
                assign place_ok[gi] = blank_en_q ? blank_in[gi]
                                                 : (NUM_DIGITS == 2);
            end else begin : g_upper_place
                assign place_ok[gi] = blank_en_q
                    ? (blank_in[gi] & (digits_q[(gi-1)*4 +: 4] != 4'h0))
                    : (gi == NUM_DIGITS - 1);
            end

            ssd_digit_decode #(
                .IS_LSB (gi == 0)
            ) u_decode (
                .nibble_i   (digits_q[gi*4 +: 4]),
                .blank_i    (blank_in[gi]),
                .minus_i    (minus_in[gi]),
                .place_ok_i (place_ok[gi]),
                .glyph_o    (glyph[gi]),
                .blank_o    (blank_out[gi]),
                .minus_o    (minus_out[gi])
            );
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        state_d = (cnt_d < CNT_GUARD) ? ST_GUARD : ST_ON;
    end

    always_comb begin
        logic [6:0]            seg_raw;
        logic                  dp_raw;
        logic [NUM_DIGITS-1:0] an_raw;
        seg_raw = GLYPH_BLANK;
        dp_raw  = 1'b0;
        an_raw  = '0;
        if (state_q == ST_ON) begin
            seg_raw        = glyph[idx_q];
            dp_raw         = dp_in_q[idx_q];
            an_raw[idx_q]  = 1'b1;
        end
        seg_d    = seg_raw ^ {7{SEG_INVERT}};
        dp_out_d = dp_raw ^ SEG_INVERT;
        an_d     = an_raw ^ {NUM_DIGITS{AN_INVERT}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q     <= '0;
            dp_in_q      <= '0;
            neg_q        <= 1'b0;
            blank_en_q   <= 1'b0;
            cnt_q        <= '0;
            idx_q        <= '0;
            state_q      <= ST_GUARD;
            seg_q        <= {7{SEG_INVERT}};
            dp_out_q     <= SEG_INVERT;
            an_q         <= {NUM_DIGITS{AN_INVERT}};
            minus_lost_q <= 1'b0;
        end else begin
            if (load) begin
                digits_q   <= digits;
                dp_in_q    <= dp_in;
                neg_q      <= neg;
                blank_en_q <= blank_en;
            end
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            seg_q        <= seg_d;
            dp_out_q     <= dp_out_d;
            an_q         <= an_d;
            minus_lost_q <= minus_out[0];
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_out_q;
    assign an         = an_q;
    assign minus_lost = minus_lost_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver: vector table of loaded values plus scan-timing and reset sequences.
module tb_ssd_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic        neg;
    logic        blank_en;
    logic        load;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        minus_lost;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ssd_scan_driver #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (8),
        .GUARD      (2),
        .SEG_INVERT (1'b0),
        .AN_INVERT  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp_in      (dp_in),
        .neg        (neg),
        .blank_en   (blank_en),
        .load       (load),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .minus_lost (minus_lost)
    );

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dpv;
        logic        neg;
        logic        blank;
        logic [27:0] exp_seg;   // {digit3, digit2, digit1, digit0}
        logic        exp_lost;
    } vec_t;

    vec_t       vecs [10];
    logic [6:0] cap_seg [4];
    logic [3:0] cap_dp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic n, input logic b);
        @(negedge clk);
        digits   = d;
        dp_in    = p;
        neg      = n;
        blank_en = b;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Collects one glyph and dp per digit from the ON phases; flags illegal an or lit segments in guard.
    task automatic capture_frame(output bit ok);
        bit [3:0] seen;
        bit       bad;
        bit       hit;
        seen = '0;
        bad  = 1'b0;
        for (int c = 0; c < 48 && seen != 4'hF; c++) begin
            @(negedge clk);
            if (an != 4'hF) begin
                hit = 1'b0;
                for (int d = 0; d < 4; d++) begin
                    if (an == ~(4'b0001 << d)) begin
                        cap_seg[d] = seg;
                        cap_dp[d]  = dp;
                        seen[d]    = 1'b1;
                        hit        = 1'b1;
                    end
                end
                if (!hit) bad = 1'b1;
            end else if (seg != 7'h00 || dp != 1'b0) begin
                bad = 1'b1;
            end
        end
        ok = (seen == 4'hF) && !bad;
    endtask

    // Sample k after the first non-reset edge reflects counter value (k-1); shadow is all-zero here.
    task automatic check_timing(input int ncyc, input string tag);
        int         c;
        int         slot;
        logic [3:0] exp_an;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            c      = (k - 1) % 8;
            slot   = ((k - 1) / 8) % 4;
            exp_an = 4'hF;
            if (c >= 2) exp_an[slot] = 1'b0;
            check({tag, "_an"}, 32'(an), 32'(exp_an));
            check({tag, "_seg"}, 32'(seg), (c >= 2) ? 32'h3F : 32'h0);
        end
        $display("timing %s: %0d cycles checked", tag, ncyc);
    endtask

    initial begin
        bit         ok;
        bit         found;
        logic [6:0] prev_seg [4];

        vecs[0] = '{16'h0042, 4'b0000, 1'b1, 1'b1, {7'h00, 7'h40, 7'h66, 7'h5B}, 1'b0};
        vecs[1] = '{16'h1234, 4'b0000, 1'b1, 1'b1, {7'h06, 7'h5B, 7'h4F, 7'h66}, 1'b1};
        vecs[2] = '{16'hABCD, 4'b0000, 1'b0, 1'b0, {7'h77, 7'h7C, 7'h39, 7'h5E}, 1'b0};
        vecs[3] = '{16'h0000, 4'b0000, 1'b1, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, 1'b0};
        vecs[4] = '{16'h0042, 4'b1010, 1'b1, 1'b0, {7'h40, 7'h3F, 7'h66, 7'h5B}, 1'b0};
        vecs[5] = '{16'h0507, 4'b0001, 1'b1, 1'b1, {7'h40, 7'h6D, 7'h3F, 7'h07}, 1'b0};
        vecs[6] = '{16'h0008, 4'b1000, 1'b0, 1'b1, {7'h00, 7'h00, 7'h00, 7'h7F}, 1'b0};
        vecs[7] = '{16'h00E0, 4'b0000, 1'b1, 1'b1, {7'h00, 7'h40, 7'h79, 7'h3F}, 1'b0};
        vecs[8] = '{16'h000F, 4'b0000, 1'b1, 1'b1, {7'h00, 7'h00, 7'h40, 7'h71}, 1'b0};
        vecs[9] = '{16'h9876, 4'b0101, 1'b1, 1'b0, {7'h6F, 7'h7F, 7'h07, 7'h7D}, 1'b1};

        rst = 1'b1; digits = '0; dp_in = '0; neg = 1'b0; blank_en = 1'b0; load = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_an", 32'(an), 32'hF);
        check("reset_seg", 32'(seg), 32'h0);
        check("reset_dp", 32'(dp), 32'h0);
        check("reset_lost", 32'(minus_lost), 32'h0);
        $display("reset: an=%b seg=%b dp=%b lost=%b", an, seg, dp, minus_lost);

        rst = 1'b0;
        check_timing(40, "scan");

        for (int v = 0; v < 10; v++) begin
            do_load(vecs[v].digits, vecs[v].dpv, vecs[v].neg, vecs[v].blank);
            repeat (2) @(negedge clk);
            capture_frame(ok);
            check($sformatf("v%0d_frame", v), 32'(ok), 32'h1);
            for (int d = 0; d < 4; d++) begin
                check($sformatf("v%0d_seg%0d", v, d), 32'(cap_seg[d]), 32'(vecs[v].exp_seg[d*7 +: 7]));
            end
            check($sformatf("v%0d_dp", v), 32'(cap_dp), 32'(vecs[v].dpv));
            check($sformatf("v%0d_lost", v), 32'(minus_lost), 32'(vecs[v].exp_lost));
            $display("vector %0d: digits=%h neg=%b blank=%b seg3..0=%h %h %h %h dp=%b lost=%b",
                     v, vecs[v].digits, vecs[v].neg, vecs[v].blank,
                     cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0], cap_dp, minus_lost);
        end

        // Inputs change without load: display must stay at the last loaded value.
        for (int d = 0; d < 4; d++) prev_seg[d] = cap_seg[d];
        @(negedge clk);
        digits = 16'h5555; dp_in = 4'b1111; neg = 1'b0; blank_en = 1'b1;
        repeat (3) @(negedge clk);
        capture_frame(ok);
        check("noload_frame", 32'(ok), 32'h1);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("noload_seg%0d", d), 32'(cap_seg[d]), 32'(vecs[9].exp_seg[d*7 +: 7]));
        end
        check("noload_dp", 32'(cap_dp), 32'(vecs[9].dpv));
        check("noload_lost", 32'(minus_lost), 32'h1);
        $display("noload: seg3..0=%h %h %h %h (was %h %h %h %h)", cap_seg[3], cap_seg[2], cap_seg[1],
                 cap_seg[0], prev_seg[3], prev_seg[2], prev_seg[1], prev_seg[0]);

        // Reset in the middle of digit 2's ON phase, coinciding with a load.
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (an == 4'b1011) found = 1'b1;
        end
        check("digit2_reached", 32'(found), 32'h1);
        @(negedge clk);
        rst = 1'b1; load = 1'b1;
        digits = 16'hFFFF; dp_in = 4'hF; neg = 1'b1; blank_en = 1'b1;
        @(negedge clk);
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_seg", 32'(seg), 32'h0);
        check("midrst_dp", 32'(dp), 32'h0);
        check("midrst_lost", 32'(minus_lost), 32'h0);
        $display("midreset: an=%b seg=%b lost=%b", an, seg, minus_lost);
        rst = 1'b0; load = 1'b0;
        check_timing(12, "postrst");

        capture_frame(ok);
        check("postrst_frame", 32'(ok), 32'h1);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("postrst_seg%0d", d), 32'(cap_seg[d]), 32'h3F);
        end
        check("postrst_dp", 32'(cap_dp), 32'h0);
        check("postrst_lost", 32'(minus_lost), 32'h0);
        $display("postreset: seg3..0=%h %h %h %h dp=%b", cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0], cap_dp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
